// File: rtl/fpu_mul_wb_buffer.sv
// rtl/fpu_mul_wb_buffer.sv - FP multiplier result FIFO toward VGPR writeback with sticky IEEE status flags
module fpu_mul_wb_buffer #(
  parameter int BIT_WIDTH  = 32,
  parameter int DEPTH      = 4,
  parameter int VDST_WIDTH = 8,
  parameter int LANE_WIDTH = 5
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [BIT_WIDTH-1:0]       i_result,
  input  logic                       i_inexact,
  input  logic [VDST_WIDTH-1:0]      i_vdst,
  input  logic [LANE_WIDTH-1:0]      i_lane,
  output logic                       o_wb_valid,
  input  logic                       i_wb_ready,
  output logic [BIT_WIDTH-1:0]       o_wb_data,
  output logic [VDST_WIDTH-1:0]      o_wb_vdst,
  output logic [LANE_WIDTH-1:0]      o_wb_lane,
  output logic [$clog2(DEPTH):0]     o_count,
  input  logic                       i_status_clr,
  output logic                       o_flag_nx,
  output logic                       o_flag_of,
  output logic                       o_flag_uf
);

  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int EXP_WIDTH = (BIT_WIDTH == 64) ? 11 : (BIT_WIDTH == 128) ? 15 : 8;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [BIT_WIDTH-1:0]  dataMem [DEPTH];
  logic [VDST_WIDTH-1:0] vdstMem [DEPTH];
  logic [LANE_WIDTH-1:0] laneMem [DEPTH];

  logic [PTR_W-1:0]     rdPtr;
  logic [PTR_W-1:0]     wrPtr;
  logic [CNT_W-1:0]     count;
  logic                 flagNx;
  logic                 flagOf;
  logic                 flagUf;
  logic                 push;
  logic                 pop;
  logic [EXP_WIDTH-1:0] expField;
  logic                 nxEv;
  logic                 ofEv;
  logic                 ufEv;

  // Ready is a function of occupancy alone so a full buffer never accepts, even on a pop cycle.
  assign o_ready    = (count != FULL_COUNT);
  assign o_wb_valid = (count != '0);
  assign push       = i_valid & o_ready;
  assign pop        = o_wb_valid & i_wb_ready;

  assign expField = i_result[BIT_WIDTH-2 -: EXP_WIDTH];
  assign nxEv     = i_inexact;
  assign ofEv     = &expField;
  assign ufEv     = ~|expField & i_inexact;

  // Head fields read zero while empty so stale storage never leaks after reset.
  assign o_wb_data = o_wb_valid ? dataMem[rdPtr] : '0;
  assign o_wb_vdst = o_wb_valid ? vdstMem[rdPtr] : '0;
  assign o_wb_lane = o_wb_valid ? laneMem[rdPtr] : '0;
  assign o_count   = count;
  assign o_flag_nx = flagNx;
  assign o_flag_of = flagOf;
  assign o_flag_uf = flagUf;

  always_ff @(posedge i_clk) begin
    if (push) begin
      dataMem[wrPtr] <= i_result;
      vdstMem[wrPtr] <= i_vdst;
      laneMem[wrPtr] <= i_lane;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rdPtr  <= '0;
      wrPtr  <= '0;
      count  <= '0;
      flagNx <= 1'b0;
      flagOf <= 1'b0;
      flagUf <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // An event in the same cycle as a clear survives the clear.
      flagNx <= (i_status_clr ? 1'b0 : flagNx) | (push & nxEv);
      flagOf <= (i_status_clr ? 1'b0 : flagOf) | (push & ofEv);
      flagUf <= (i_status_clr ? 1'b0 : flagUf) | (push & ufEv);
    end
  end

endmodule

// File: tb/tb_fpu_mul_wb_buffer.sv
// tb/tb_fpu_mul_wb_buffer.sv - directed self-checking bench for fpu_mul_wb_buffer
module tb_fpu_mul_wb_buffer;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_result;
  logic        i_inexact;
  logic [7:0]  i_vdst;
  logic [4:0]  i_lane;
  logic        o_wb_valid;
  logic        i_wb_ready;
  logic [31:0] o_wb_data;
  logic [7:0]  o_wb_vdst;
  logic [4:0]  o_wb_lane;
  logic [2:0]  o_count;
  logic        i_status_clr;
  logic        o_flag_nx;
  logic        o_flag_of;
  logic        o_flag_uf;

  int nTests = 0;
  int nFail  = 0;

  fpu_mul_wb_buffer dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_result     (i_result),
    .i_inexact    (i_inexact),
    .i_vdst       (i_vdst),
    .i_lane       (i_lane),
    .o_wb_valid   (o_wb_valid),
    .i_wb_ready   (i_wb_ready),
    .o_wb_data    (o_wb_data),
    .o_wb_vdst    (o_wb_vdst),
    .o_wb_lane    (o_wb_lane),
    .o_count      (o_count),
    .i_status_clr (i_status_clr),
    .o_flag_nx    (o_flag_nx),
    .o_flag_of    (o_flag_of),
    .o_flag_uf    (o_flag_uf)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nTests++;
    assert (obs === expv) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the falling edge after each rising edge.
  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic setIn(input logic v, input logic [31:0] r, input logic nx,
                       input logic [7:0] vd, input logic [4:0] ln);
    i_valid   = v;
    i_result  = r;
    i_inexact = nx;
    i_vdst    = vd;
    i_lane    = ln;
  endtask

  task automatic chkFlags(input string tag, input logic nx, input logic of, input logic uf);
    chk({tag, "_nx"}, 64'(o_flag_nx), 64'(nx));
    chk({tag, "_of"}, 64'(o_flag_of), 64'(of));
    chk({tag, "_uf"}, 64'(o_flag_uf), 64'(uf));
  endtask

  initial begin
    i_reset = 1'b1;
    i_wb_ready = 1'b0;
    i_status_clr = 1'b0;
    setIn(1'b0, 32'h0, 1'b0, 8'h0, 5'h0);
    @(negedge i_clk);
    step();
    step();
    i_reset = 1'b0;

    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_wbvalid", 64'(o_wb_valid), 64'd0);
    chk("rst_data", 64'(o_wb_data), 64'd0);
    chk("rst_vdst", 64'(o_wb_vdst), 64'd0);
    chk("rst_lane", 64'(o_wb_lane), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd1);
    chkFlags("rst", 1'b0, 1'b0, 1'b0);

    // single push, visible at head one cycle later
    setIn(1'b1, 32'h40C00000, 1'b0, 8'd3, 5'd7);
    chk("t1_no_bypass", 64'(o_wb_valid), 64'd0);
    step();
    i_valid = 1'b0;
    chk("t1_wbvalid", 64'(o_wb_valid), 64'd1);
    chk("t1_data", 64'(o_wb_data), 64'h40C00000);
    chk("t1_vdst", 64'(o_wb_vdst), 64'd3);
    chk("t1_lane", 64'(o_wb_lane), 64'd7);
    chk("t1_count", 64'(o_count), 64'd1);
    chkFlags("t1", 1'b0, 1'b0, 1'b0);
    step();
    chk("t1_hold", 64'(o_wb_data), 64'h40C00000);
    i_wb_ready = 1'b1;
    step();
    i_wb_ready = 1'b0;
    chk("t1_drained", 64'(o_count), 64'd0);

    // fill, overflow attempt dropped, drain in order
    for (int k = 0; k < 4; k++) begin
      setIn(1'b1, 32'h3F800000 + 32'(k), 1'b0, 8'(10 + k), 5'(k));
      step();
    end
    chk("t2_count_full", 64'(o_count), 64'd4);
    chk("t2_ready_full", 64'(o_ready), 64'd0);
    setIn(1'b1, 32'hDEADBEEF, 1'b0, 8'd99, 5'd31);
    step();
    i_valid = 1'b0;
    chk("t2_drop_count", 64'(o_count), 64'd4);
    i_wb_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_data%0d", k), 64'(o_wb_data), 64'h3F800000 + 64'(k));
      chk($sformatf("t2_vdst%0d", k), 64'(o_wb_vdst), 64'(10 + k));
      chk($sformatf("t2_lane%0d", k), 64'(o_wb_lane), 64'(k));
      step();
    end
    i_wb_ready = 1'b0;
    chk("t2_empty_count", 64'(o_count), 64'd0);
    chk("t2_empty_valid", 64'(o_wb_valid), 64'd0);

    // full with valid and pop: pop only, then simultaneous push/pop
    for (int k = 0; k < 4; k++) begin
      setIn(1'b1, 32'h41000000 + 32'(k), 1'b0, 8'(20 + k), 5'(k));
      step();
    end
    setIn(1'b1, 32'h42000000, 1'b0, 8'd50, 5'd9);
    i_wb_ready = 1'b1;
    step();
    chk("t3_pop_only_count", 64'(o_count), 64'd3);
    chk("t3_ready_back", 64'(o_ready), 64'd1);
    chk("t3_head1", 64'(o_wb_data), 64'h41000001);
    step();
    i_valid = 1'b0;
    chk("t3_pushpop_count", 64'(o_count), 64'd3);
    chk("t3_head2", 64'(o_wb_data), 64'h41000002);
    step();
    chk("t3_head3", 64'(o_wb_data), 64'h41000003);
    step();
    chk("t3_head4", 64'(o_wb_data), 64'h42000000);
    chk("t3_vdst4", 64'(o_wb_vdst), 64'd50);
    step();
    i_wb_ready = 1'b0;
    chk("t3_empty", 64'(o_count), 64'd0);
    chkFlags("t3", 1'b0, 1'b0, 1'b0);

    // sticky flags
    setIn(1'b1, 32'h7F800000, 1'b1, 8'd1, 5'd1);
    step();
    chkFlags("t4a", 1'b1, 1'b1, 1'b0);
    setIn(1'b1, 32'h00000000, 1'b1, 8'd2, 5'd2);
    step();
    i_valid = 1'b0;
    chkFlags("t4b", 1'b1, 1'b1, 1'b1);
    i_wb_ready = 1'b1;
    step();
    chkFlags("t4_pop_keeps", 1'b1, 1'b1, 1'b1);
    i_status_clr = 1'b1;
    step();
    i_status_clr = 1'b0;
    i_wb_ready = 1'b0;
    chkFlags("t4_clr", 1'b0, 1'b0, 1'b0);
    chk("t4_count", 64'(o_count), 64'd0);

    // clear and event in the same cycle
    i_status_clr = 1'b1;
    setIn(1'b1, 32'h3F800000, 1'b1, 8'd5, 5'd5);
    step();
    i_status_clr = 1'b0;
    i_valid = 1'b0;
    chkFlags("t5", 1'b1, 1'b0, 1'b0);
    chk("t5_count", 64'(o_count), 64'd1);

    // reset mid-operation, then wrap via streaming push/pop
    for (int k = 0; k < 2; k++) begin
      setIn(1'b1, 32'h44000000 + 32'(k), 1'b0, 8'd7, 5'd3);
      step();
    end
    chk("t6_pre_count", 64'(o_count), 64'd3);
    i_reset = 1'b1;
    i_wb_ready = 1'b1;
    step();
    i_reset = 1'b0;
    i_valid = 1'b0;
    i_wb_ready = 1'b0;
    chk("t6_rst_count", 64'(o_count), 64'd0);
    chk("t6_rst_valid", 64'(o_wb_valid), 64'd0);
    chk("t6_rst_data", 64'(o_wb_data), 64'd0);
    chkFlags("t6_rst", 1'b0, 1'b0, 1'b0);

    i_wb_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      setIn(1'b1, 32'h3C000000 + 32'(k), 1'b0, 8'(100 + k), 5'(k));
      step();
      chk($sformatf("t6_wrap_count%0d", k), 64'(o_count), 64'd1);
      chk($sformatf("t6_wrap_data%0d", k), 64'(o_wb_data), 64'h3C000000 + 64'(k));
      chk($sformatf("t6_wrap_lane%0d", k), 64'(o_wb_lane), 64'(k));
    end
    i_valid = 1'b0;
    step();
    i_wb_ready = 1'b0;
    chk("t6_final_count", 64'(o_count), 64'd0);
    chk("t6_final_valid", 64'(o_wb_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
